riscv_fetch: RTL and testbench
==============================

RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), is the bubble placed on Instruction_o.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 stall_i  in  1  downstream stall; the IF/ID outputs hold their value.
REQ-006 redirect_i  in  1  branch/JAL taken; restart fetch at redirect_pc_i.
REQ-007 redirect_pc_i  in  `dw  new fetch address.
REQ-008 imem_req_o  out  1  one-cycle instruction-memory read request pulse.
REQ-009 imem_addr_o  out  `dw  request address, valid while imem_req_o=1.
REQ-010 imem_rvalid_i  in  1  read data valid, one cycle, arriving at least 1 cycle after the request.
REQ-011 imem_rdata_i  in  `dw  instruction word, valid with imem_rvalid_i.
REQ-012 Instruction_o  out  `dw  IF/ID instruction to the decoder.
REQ-013 pc_o  out  `dw  PC of Instruction_o.
REQ-014 valid_o  out  1  1 = Instruction_o is a real instruction; 0 = bubble.

Function
REQ-015 The block SHALL use FSM states S_RESET, S_WAIT, S_HOLD and S_KILL, with at most one memory request outstanding.
REQ-016 S_RESET -> S_WAIT: on the first edge after reset release, pulse imem_req_o with imem_addr_o = pc.
REQ-017 S_WAIT, imem_rvalid_i=1, stall_i=0: load Instruction_o=imem_rdata_i, pc_o=pc, valid_o=1; pc <= pc+4; pulse the next request at the new pc on the following cycle; stay in S_WAIT.
REQ-018 S_WAIT, imem_rvalid_i=1, stall_i=1: capture the word and its pc in a one-entry hold buffer; the IF/ID outputs are unchanged; go to S_HOLD; issue no request.
REQ-019 S_HOLD, stall_i=0: move the buffer to the IF/ID outputs with valid_o=1; pc <= pc+4; request the next pc; go to S_WAIT.
REQ-020 Any cycle with stall_i=0 and no instruction loaded SHALL load Instruction_o=NOP_INSTR and valid_o=0; pc_o is unchanged.
REQ-021 redirect_i=1 SHALL have priority over stall_i and over any response:
- pc <= {redirect_pc_i[31:2],2'b00};
- IF/ID <= NOP_INSTR with valid_o=0;
- the hold buffer is cleared;
- if a request is outstanding and its response has not arrived in this cycle, go to S_KILL; otherwise request the new pc on the next cycle and go to S_WAIT.
REQ-022 S_KILL: discard the next imem_rvalid_i; on that cycle go to S_WAIT and request pc on the following cycle; a further redirect in S_KILL only updates pc.
REQ-023 pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-024 Peak throughput with 1-cycle memory latency is one instruction per 2 cycles.
REQ-025 imem_rvalid_i while no request is outstanding SHALL be ignored.

Reset
REQ-026 While rst_i=1, without waiting for a clock edge:
- pc = RESET_PC, state = S_RESET;
- imem_req_o = 0, imem_addr_o = RESET_PC;
- Instruction_o = NOP_INSTR, pc_o = RESET_PC, valid_o = 0;
- the hold buffer is empty.
REQ-027 Reset asserted mid-request SHALL abandon the request; any response arriving after reset release SHALL be discarded, because no request is outstanding.

Structure
REQ-028 NOP_INSTR, RESET_PC and the FSM state encodings SHALL live in the shared define.h, alongside `dw and `ZERO.
REQ-029 The IF/ID register SHALL be one sub-module, riscv_if_id_reg, with stall, flush and load controls; the FSM, pc and hold buffer live in riscv_fetch.

Verification
REQ-030 Reset release, 1-cycle memory returning 32'h00A00093 then 32'h00100113: the first request is at 0x0; valid_o=1 with pc_o=0x0 and then pc_o=0x4, two cycles apart.
REQ-031 stall_i held 3 cycles while the response arrives: the outputs are frozen; after release, the buffered word appears with the correct pc_o, and the next request goes to pc+4.
REQ-032 redirect_i with redirect_pc_i=0x103 while a request is outstanding: the stale response is dropped; the next request is at 0x100; valid_o=0 until the 0x100 word arrives.
REQ-033 redirect_i and stall_i asserted together with imem_rvalid_i=1: the flush wins; Instruction_o=0x00000013, valid_o=0.
REQ-034 pc=0xFFFFFFFC fetch completes: the next imem_addr_o = 0x00000000.
REQ-035 rst_i asserted asynchronously between clock edges during S_WAIT: all outputs reach reset values immediately; a late imem_rvalid_i after release is ignored.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared constants, state encoding and address helper for the fetch stage.
package riscv_fetch_pkg;

  localparam int unsigned DW = 32;

  localparam logic [DW-1:0] ZERO              = '0;
  localparam logic [DW-1:0] DEFAULT_RESET_PC  = ZERO;
  localparam logic [DW-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } fetch_state_e;

  // Instruction fetch is word aligned; low address bits are forced to zero.
  function automatic logic [DW-1:0] align_pc(input logic [DW-1:0] addr);
    return addr & {{(DW-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/riscv_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module riscv_if_id_reg
  import riscv_fetch_pkg::*;
#(
  parameter logic [DW-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [DW-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          load,
  input  logic [DW-1:0] load_instr,
  input  logic [DW-1:0] load_pc,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] pc,
  output logic          valid
);

  // Register update; pc is left untouched on flush and bubble cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP_INSTR;
      pc    <= RESET_PC;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr <= load_instr;
        pc    <= load_pc;
        valid <= 1'b1;
      end else begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: pc, single-outstanding imem request FSM and a one-entry hold buffer.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [DW-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [DW-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [DW-1:0] redirect_pc_i,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [DW-1:0] Instruction_o,
  output logic [DW-1:0] pc_o,
  output logic          valid_o
);

  fetch_state_e  state, state_n;
  logic [DW-1:0] pc, pc_n;
  logic [DW-1:0] hold_instr, hold_instr_n;
  logic          hold_valid, hold_valid_n;
  logic          req, req_n;
  logic          pending, pending_n;
  logic          resp;
  logic          flush;
  logic          load;
  logic [DW-1:0] load_instr;

  // A response only counts once its request has been seen by memory.
  assign resp        = pending & imem_rvalid_i;
  assign imem_req_o  = req;
  assign imem_addr_o = pc;

  // State, pc, request pulse, outstanding flag and hold buffer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      req        <= 1'b0;
      pending    <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req        <= req_n;
      pending    <= pending_n;
      hold_instr <= hold_instr_n;
      hold_valid <= hold_valid_n;
    end
  end

  // Next-state and IF/ID control; redirect overrides every state.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_n        = 1'b0;
    hold_instr_n = hold_instr;
    hold_valid_n = hold_valid;
    flush        = 1'b0;
    load         = 1'b0;
    load_instr   = imem_rdata_i;

    // Outstanding from the cycle the pulse is on the bus until rvalid.
    if (req) begin
      pending_n = 1'b1;
    end else if (imem_rvalid_i) begin
      pending_n = 1'b0;
    end else begin
      pending_n = pending;
    end

    if (redirect_i) begin
      pc_n         = align_pc(redirect_pc_i);
      flush        = 1'b1;
      hold_valid_n = 1'b0;
      // A request still in flight (or just issued) must be drained first.
      if (req || (pending && !imem_rvalid_i)) begin
        state_n = S_KILL;
      end else begin
        state_n = S_WAIT;
        req_n   = 1'b1;
      end
    end else begin
      unique case (state)
        S_RESET: begin
          state_n = S_WAIT;
          req_n   = 1'b1;
        end
        S_WAIT: begin
          if (resp) begin
            if (stall_i) begin
              hold_instr_n = imem_rdata_i;
              hold_valid_n = 1'b1;
              state_n      = S_HOLD;
            end else begin
              load  = 1'b1;
              pc_n  = pc + 32'd4;
              req_n = 1'b1;
            end
          end
        end
        // pc is frozen while holding, so it still names the buffered word.
        S_HOLD: begin
          if (!stall_i && hold_valid) begin
            load         = 1'b1;
            load_instr   = hold_instr;
            hold_valid_n = 1'b0;
            pc_n         = pc + 32'd4;
            req_n        = 1'b1;
            state_n      = S_WAIT;
          end
        end
        S_KILL: begin
          if (resp) begin
            state_n = S_WAIT;
            req_n   = 1'b1;
          end
        end
        default: state_n = S_RESET;
      endcase
    end
  end

  riscv_if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk_i),
    .rst        (rst_i),
    .stall      (stall_i),
    .flush      (flush),
    .load       (load),
    .load_instr (load_instr),
    .load_pc    (pc),
    .instr      (Instruction_o),
    .pc         (pc_o),
    .valid      (valid_o)
  );

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch with a simple instruction memory and scoreboard.
module tb_riscv_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] Instruction_o;
  logic [31:0] pc_o;
  logic        valid_o;

  exp_t        exp_q[$];
  int unsigned pop_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  // memory model state
  logic        slot_v   = 1'b0;
  logic [31:0] slot_a   = '0;
  int unsigned slot_cnt = 0;
  int unsigned mem_lat  = 0;
  int unsigned budget   = 0;
  logic        stray    = 1'b0;

  riscv_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .Instruction_o (Instruction_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return a ^ 32'h5A5A_0003;
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.pc    = a;
    e.instr = d;
    exp_q.push_back(e);
  endtask

  // One clock cycle: memory drives after the edge, scoreboard and request capture at negedge.
  task automatic step();
    logic st, rd, rs;
    exp_t e;
    @(posedge clk);
    st = stall_i;
    rd = redirect_i;
    rs = rst_i;
    cyc++;
    #1;
    imem_rvalid_i = 1'b0;
    if (stray) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_0BAD;
    end else if (slot_v) begin
      if (slot_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(slot_a);
        slot_v        = 1'b0;
      end else begin
        slot_cnt--;
      end
    end
    @(negedge clk);
    if (!rs && !st && !rd && valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: pc_o=%h Instruction_o=%h, required no valid instruction", pc_o, Instruction_o);
      end else begin
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if ({pc_o, Instruction_o} !== {e.pc, e.instr}) begin
          errors++;
          $display("FAIL scoreboard: pc_o=%h Instruction_o=%h, required pc=%h instr=%h", pc_o, Instruction_o, e.pc, e.instr);
        end
      end
    end
    if (imem_req_o === 1'b1 && !slot_v && budget > 0) begin
      slot_v   = 1'b1;
      slot_a   = imem_addr_o;
      slot_cnt = mem_lat;
      budget--;
    end
  endtask

  task automatic drain(input int unsigned max_cycles, input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  task automatic apply_reset();
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    stray         = 1'b0;
    mem_lat       = 0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_i = 1'b1;
    step();
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_req: req=%b addr=%h, required req=0 addr=00000000", imem_req_o, imem_addr_o);
    end
    checks++;
    if ({Instruction_o, pc_o, valid_o} !== {NOP, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ifid: instr=%h pc=%h valid=%b, required %h 00000000 0", Instruction_o, pc_o, valid_o, NOP);
    end
  endtask

  task automatic test_fetch();
    int unsigned gap;
    apply_reset();
    budget = 2;
    push_exp(32'h0, 32'h00A0_0093);
    push_exp(32'h4, 32'h0010_0113);
    step();
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, required req=1 addr=00000000", imem_req_o, imem_addr_o);
    end
    drain(20, "fetch");
    checks++;
    if (pop_cyc.size() < 2) begin
      errors++;
      $display("FAIL fetch_gap: %0d instructions seen, required 2", pop_cyc.size());
    end else begin
      gap = pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2];
      if (gap != 2) begin
        errors++;
        $display("FAIL fetch_gap: %0d cycles between instructions, required 2", gap);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    budget = 2;
    push_exp(32'h0, 32'h00A0_0093);
    push_exp(32'h4, 32'h0010_0113);
    step();
    step();
    step();
    checks++;
    if ({valid_o, pc_o} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL pre_stall: valid=%b pc=%h, required 1 00000000", valid_o, pc_o);
    end
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({Instruction_o, pc_o, valid_o, imem_req_o} !== {32'h00A0_0093, 32'h0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_frozen: instr=%h pc=%h valid=%b req=%b, required 00a00093 00000000 1 0",
                 Instruction_o, pc_o, valid_o, imem_req_o);
      end
    end
    stall_i = 1'b0;
    step();
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL stall_next_req: req=%b addr=%h, required req=1 addr=00000008", imem_req_o, imem_addr_o);
    end
    drain(5, "stall");
  endtask

  task automatic test_redirect();
    apply_reset();
    budget = 2;
    push_exp(32'h100, mem_word(32'h100));
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    checks++;
    if ({Instruction_o, valid_o, imem_req_o} !== {NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL redirect_kill: instr=%h valid=%b req=%b, required %h 0 0", Instruction_o, valid_o, imem_req_o, NOP);
    end
    step();
    checks++;
    if ({valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL redirect_req: valid=%b req=%b addr=%h, required 0 1 00000100", valid_o, imem_req_o, imem_addr_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redirect_bubble: valid=%b, required 0", valid_o);
    end
    drain(5, "redirect");
  endtask

  task automatic test_flush_priority();
    apply_reset();
    budget = 3;
    push_exp(32'h0, 32'h00A0_0093);
    push_exp(32'h200, mem_word(32'h200));
    step();
    step();
    step();
    step();
    stall_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    step();
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    checks++;
    if ({Instruction_o, valid_o} !== {NOP, 1'b0}) begin
      errors++;
      $display("FAIL flush_wins: instr=%h valid=%b, required %h 0", Instruction_o, valid_o, NOP);
    end
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL flush_req: req=%b addr=%h, required req=1 addr=00000200", imem_req_o, imem_addr_o);
    end
    drain(6, "flush");
  endtask

  task automatic test_wrap();
    apply_reset();
    budget = 1;
    push_exp(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 1'b0;
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_first_req: req=%b addr=%h, required req=1 addr=fffffffc", imem_req_o, imem_addr_o);
    end
    step();
    step();
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_next_req: req=%b addr=%h, required req=1 addr=00000000", imem_req_o, imem_addr_o);
    end
    drain(3, "wrap");
  endtask

  task automatic test_stray();
    apply_reset();
    budget = 1;
    push_exp(32'h0, 32'h00A0_0093);
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_ignored: valid=%b instr=%h, required valid=0", valid_o, Instruction_o);
    end
    drain(4, "stray");
  endtask

  task automatic test_async_reset();
    apply_reset();
    budget = 2;
    push_exp(32'h0, 32'h00A0_0093);
    step();
    step();
    step();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset_req: req=%b addr=%h, required req=0 addr=00000000", imem_req_o, imem_addr_o);
    end
    checks++;
    if ({Instruction_o, pc_o, valid_o} !== {NOP, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_ifid: instr=%h pc=%h valid=%b, required %h 00000000 0", Instruction_o, pc_o, valid_o, NOP);
    end
    step();
    rst_i  = 1'b0;
    budget = 1;
    push_exp(32'h0, 32'h00A0_0093);
    step();
    checks++;
    if ({valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL late_rvalid: valid=%b req=%b addr=%h, required 0 1 00000000", valid_o, imem_req_o, imem_addr_o);
    end
    drain(6, "async_reset");
  endtask

  initial begin
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_flush_priority();
    test_wrap();
    test_stray();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
